sar_search_ctrl: RTL and testbench
==================================

# sar_search_ctrl

Successive-approximation search controller that drives the B operand of an external combinational magnitude comparator and consumes its less/greater/equal flags to recover an unknown W-bit value presented on the comparator's A operand. It sits beside the comparator datapath. It turns the comparator's relation flags back into a binary value: the comparator produces flags from values, and this block produces the value from the flags. It runs a bit-serial MSB-first search and reports the recovered value, a found flag, and a flag-consistency error.

## Interface
Parameters:
- W, 4, operand width; legal range 2..16.

Ports:
- clk  in  1  rising-edge clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a new search; sampled only in IDLE.
- cmp_less  in  1  comparator flag: target < guess.
- cmp_greater  in  1  comparator flag: target > guess.
- cmp_equal  in  1  comparator flag: target == guess.
- guess  out  W  value driven to the comparator B operand; registered.
- busy  out  1  high in TRIAL and VERIFY.
- done  out  1  one-cycle pulse when a search ends.
- result  out  W  recovered value; held from done until the next accepted start.
- found  out  1  verify or early-exit equal seen; valid with and after done.
- err  out  1  inconsistent comparator flags seen; valid with and after done.

## Operation
- States: IDLE, TRIAL, VERIFY, DONE. Bit index i counts W-1 down to 0.
- IDLE: guess=0, busy=0. When start=1, load acc=0 and i=W-1, and clear result, found and err. Then go to TRIAL with guess=1<<(W-1).
- TRIAL: guess = acc | (1<<i). Flags are sampled at the clock edge that ends the cycle.
  - less: bit i of acc stays 0.
  - greater: bit i of acc is set.
  - equal: governed by SAR_EARLY_EXIT_EN (see Configuration).
  - If i=0, go to VERIFY. Otherwise decrement i.
- VERIFY: guess = acc. If equal=1: found=1. Otherwise found=0. Go to DONE.
- DONE: done=1 for exactly one cycle, result=acc, then go to IDLE.
- Flag check, active in TRIAL and VERIFY: if the count of high flags is not exactly one, set err=1 and found=0, set result to the partial acc, and go straight to DONE.
- start is ignored outside IDLE, including in DONE.
- Comparator flags are combinational from guess; this block adds no input registers.

## Timing
- Reset values: guess=0, busy=0, done=0, result=0, found=0, err=0; state IDLE.
- Reset assertion at any point, including mid-search, forces the reset values immediately (asynchronous). No search resumes after reset release.
- Cycle numbering: start is sampled high at edge 0.
- TRIAL occupies cycles 1..W at most.
- VERIFY, when entered, occupies cycle W+1, and done is high in cycle W+2. W+2 is the maximum latency.
- Early exit at trial k (1..W): done is high in cycle k+1.
- Flag error at trial k: done is high in cycle k+1. Flag error in VERIFY: done is high in cycle W+2.
- busy falls in the same cycle that done rises.
- start may be reasserted in the cycle after done; the new search begins with that sample.

## Configuration
- SAR_EARLY_EXIT_EN defined: equal during TRIAL sets bit i and ends the search. result = guess, found=1, next state DONE; VERIFY is skipped.
- SAR_EARLY_EXIT_EN undefined: equal during TRIAL is treated as greater (bit i set) and the search continues. Every successful search runs all W trials plus VERIFY, so latency is always W+2.
- The flag check is present in both builds.

## Test plan
- W=4, target 9, SAR_EARLY_EXIT_EN defined: guess sequence 8,12,10,9, then done in cycle 5 with result=9, found=1, err=0.
- W=4, target 9, SAR_EARLY_EXIT_EN undefined: guess sequence 8,12,10,9, VERIFY guess 9, then done in cycle 6 with result=9, found=1.
- W=4, target 0: guess sequence 8,4,2,1, VERIFY guess 0, then done in cycle 6 with result=0, found=1. Target 15 with early exit: guess sequence 8,12,14,15, then done in cycle 5 with result=15.
- All flags held low after start: err=1, found=0, result=0, done in cycle 2. Both less and greater high in trial 2 for target 9: err=1, result=8, done in cycle 3.
- Reset and start handling:
  - rst_n pulled low in cycle 3 of a search: all outputs return to their reset values at once, and the state is IDLE after release.
  - start pulsed during TRIAL: ignored, with no change to the guess sequence.
  - Back-to-back start in the cycle after done: the second search runs normally.

Source files
------------

// File: rtl/sar_search_ctrl_if.sv
// Comparator-side bundle for sar_search_ctrl: start request, relation flags
// from the external comparator, and the guess/result/status outputs.
interface sar_search_ctrl_if #(
    parameter int W = 4
);
    logic         start;
    logic         cmp_less;
    logic         cmp_greater;
    logic         cmp_equal;
    logic [W-1:0] guess;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         found;
    logic         err;

    // Handshake: start is a level sampled only while idle; done is a single-cycle
    // pulse and result/found/err stay valid from done until the next accepted start.
    modport master (
        input  start, cmp_less, cmp_greater, cmp_equal,
        output guess, busy, done, result, found, err
    );

    modport slave (
        output start, cmp_less, cmp_greater, cmp_equal,
        input  guess, busy, done, result, found, err
    );
endinterface

// File: rtl/sar_search_ctrl.sv
// Successive-approximation search controller: MSB-first trials against an external
// comparator recover the comparator's A operand. Optional macro: SAR_EARLY_EXIT_EN.
module sar_search_ctrl #(
    parameter int W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    sar_search_ctrl_if.master bus,
    output logic [1:0]        dbg_state
);
    localparam int           IW  = $clog2(W);
    localparam logic [W-1:0] ONE = W'(1);
    localparam logic [W-1:0] MSB = ONE << (W - 1);

    typedef enum logic [1:0] {IDLE, TRIAL, VERIFY, DONE} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [W-1:0]   guess_q, guess_d;
    logic [W-1:0]   result_q, result_d;
    logic           found_q, found_d;
    logic           err_q, err_d;

    logic [W-1:0]   mask;
    logic [W-1:0]   set_acc;
    logic [W-1:0]   next_acc;
    logic           flags_ok;
    logic           early_hit;

    assign mask     = ONE << idx_q;
    assign set_acc  = acc_q | mask;
    assign flags_ok = (bus.cmp_less  & ~bus.cmp_greater & ~bus.cmp_equal) |
                      (~bus.cmp_less &  bus.cmp_greater & ~bus.cmp_equal) |
                      (~bus.cmp_less & ~bus.cmp_greater &  bus.cmp_equal);

`ifdef SAR_EARLY_EXIT_EN
    assign early_hit = bus.cmp_equal;
`else
    assign early_hit = 1'b0;
`endif

    // Without early exit, equal is folded into greater so the search keeps going.
    assign next_acc = (bus.cmp_greater | bus.cmp_equal) ? set_acc : acc_q;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        guess_d  = guess_q;
        result_d = result_q;
        found_d  = found_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                guess_d = '0;
                if (bus.start) begin
                    acc_d    = '0;
                    idx_d    = IW'(W - 1);
                    result_d = '0;
                    found_d  = 1'b0;
                    err_d    = 1'b0;
                    guess_d  = MSB;
                    state_d  = TRIAL;
                end
            end
            TRIAL: begin
                if (!flags_ok) begin
                    err_d    = 1'b1;
                    found_d  = 1'b0;
                    result_d = acc_q;
                    guess_d  = '0;
                    state_d  = DONE;
                end else if (early_hit) begin
                    acc_d    = set_acc;
                    result_d = guess_q;
                    found_d  = 1'b1;
                    guess_d  = '0;
                    state_d  = DONE;
                end else begin
                    acc_d = next_acc;
                    if (idx_q == '0) begin
                        guess_d = next_acc;
                        state_d = VERIFY;
                    end else begin
                        idx_d   = idx_q - 1'b1;
                        guess_d = next_acc | (mask >> 1);
                    end
                end
            end
            VERIFY: begin
                err_d    = ~flags_ok;
                found_d  = flags_ok & bus.cmp_equal;
                result_d = acc_q;
                guess_d  = '0;
                state_d  = DONE;
            end
            DONE: begin
                guess_d = '0;
                state_d = IDLE;
            end
            default: begin
                guess_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            idx_q    <= '0;
            guess_q  <= '0;
            result_q <= '0;
            found_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            guess_q  <= guess_d;
            result_q <= result_d;
            found_q  <= found_d;
            err_q    <= err_d;
        end
    end

    assign bus.guess  = guess_q;
    assign bus.busy   = (state_q == TRIAL) || (state_q == VERIFY);
    assign bus.done   = (state_q == DONE);
    assign bus.result = result_q;
    assign bus.found  = found_q;
    assign bus.err    = err_q;
    assign dbg_state  = state_q;
endmodule

// File: tb/tb_sar_search_ctrl.sv
// Directed and random searches against a behavioural comparator with flag override.
module tb_sar_search_ctrl;
  localparam int W = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sar_search_ctrl_if #(.W(W)) bus ();
  logic [1:0] dbg_state;

  sar_search_ctrl #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // comparator model; ovr_flags = {less, greater, equal}
  logic [W-1:0] target;
  logic         ovr_en;
  logic [2:0]   ovr_flags;

  always_comb begin
    if (ovr_en) begin
      {bus.cmp_less, bus.cmp_greater, bus.cmp_equal} = ovr_flags;
    end else begin
      bus.cmp_less    = (target < bus.guess);
      bus.cmp_greater = (target > bus.guess);
      bus.cmp_equal   = (target == bus.guess);
    end
  end

  // scoreboard: expected guesses, expected {err, found, result}, expected done cycle
  logic [W-1:0]   exp_q[$];
  logic [W+1:0]   res_q[$];
  int             cyc_q[$];
  int             errors = 0;
  int             checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic expect_clean(input logic [W-1:0] t);
    logic [W-1:0] a;
    logic [W-1:0] g;
    int           n;
    a = '0;
    n = 0;
    for (int i = W - 1; i >= 0; i--) begin
      g = a | (W'(1) << i);
      exp_q.push_back(g);
      n++;
`ifdef SAR_EARLY_EXIT_EN
      if (g == t) begin
        res_q.push_back({2'b01, g});
        cyc_q.push_back(n + 1);
        return;
      end
`endif
      if (t >= g) a = g;
    end
    exp_q.push_back(a);
    res_q.push_back({2'b01, a});
    cyc_q.push_back(W + 2);
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the cycle after done.
  task automatic run_search(input int pulse_cyc, input int ovr_cyc, input logic [2:0] ovr_pat);
    int           c;
    bit           seen;
    logic [W+1:0] r;
    int           ec;
    logic [W-1:0] g;
    r = '0;
    ovr_flags = ovr_pat;
    bus.start = 1'b1;
    @(posedge clk);
    c = 1;
    seen = 0;
    while (!seen && c <= 2 * W + 4) begin
      @(negedge clk);
      if (c == 1) begin
        check("clr_result", bus.result, 0);
        check("clr_found", bus.found, 0);
        check("clr_err", bus.err, 0);
      end
      if (bus.done) begin
        seen = 1;
        r  = res_q.pop_front();
        ec = cyc_q.pop_front();
        check("done_busy", bus.busy, 0);
        check("done_cycle", c, ec);
        check("result", bus.result, r[W-1:0]);
        check("found", bus.found, r[W]);
        check("err", bus.err, r[W+1]);
        check("unused_guesses", exp_q.size(), 0);
        exp_q.delete();
      end else begin
        check("busy", bus.busy, 1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL extra_trial: observed guess=%0d expected no further trial", bus.guess);
        end else begin
          g = exp_q.pop_front();
          check("guess", bus.guess, g);
        end
      end
      bus.start = (c == pulse_cyc);
      ovr_en    = (c == ovr_cyc);
      c++;
    end
    bus.start = 1'b0;
    ovr_en    = 1'b0;
    if (!seen) begin
      checks++;
      errors++;
      $error("FAIL timeout: observed no done within %0d cycles expected done", 2 * W + 4);
      exp_q.delete();
      void'(res_q.pop_front());
      void'(cyc_q.pop_front());
    end
    @(negedge clk);
    check("done_pulse", bus.done, 0);
    check("idle_guess", bus.guess, 0);
    if (seen) check("held_result", bus.result, r[W-1:0]);
  endtask

  initial begin
    logic [W-1:0] t;
    bus.start = 1'b0;
    ovr_en    = 1'b0;
    ovr_flags = 3'b000;
    target    = '0;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_guess", bus.guess, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_result", bus.result, 0);
    check("rst_found", bus.found, 0);
    check("rst_err", bus.err, 0);
    check("rst_state", dbg_state, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_state", dbg_state, 0);

    // clean searches (also back-to-back: each starts in the cycle after done)
    target = 4'd9;  expect_clean(4'd9);  run_search(0, 0, 3'b000);
    target = 4'd0;  expect_clean(4'd0);  run_search(0, 0, 3'b000);
    target = 4'd15; expect_clean(4'd15); run_search(0, 0, 3'b000);

    // all flags low in trial 1
    target = 4'd9;
    exp_q.push_back(4'd8);
    res_q.push_back({2'b10, 4'd0});
    cyc_q.push_back(2);
    run_search(0, 1, 3'b000);

    // less and greater both high in trial 2
    target = 4'd9;
    exp_q.push_back(4'd8);
    exp_q.push_back(4'd12);
    res_q.push_back({2'b10, 4'd8});
    cyc_q.push_back(3);
    run_search(0, 2, 3'b110);

    // flag error in VERIFY
    target = 4'd0;
    exp_q.push_back(4'd8); exp_q.push_back(4'd4); exp_q.push_back(4'd2);
    exp_q.push_back(4'd1); exp_q.push_back(4'd0);
    res_q.push_back({2'b10, 4'd0});
    cyc_q.push_back(W + 2);
    run_search(0, 5, 3'b000);

    // consistent but not-equal flags in VERIFY: not found, no error
    target = 4'd0;
    exp_q.push_back(4'd8); exp_q.push_back(4'd4); exp_q.push_back(4'd2);
    exp_q.push_back(4'd1); exp_q.push_back(4'd0);
    res_q.push_back({2'b00, 4'd0});
    cyc_q.push_back(W + 2);
    run_search(0, 5, 3'b100);

    // start pulsed during TRIAL is ignored
    target = 4'd9;  expect_clean(4'd9);  run_search(2, 0, 3'b000);
    target = 4'd6;  expect_clean(4'd6);  run_search(3, 0, 3'b000);

    // random targets
    for (int k = 0; k < 6; k++) begin
      t = W'($urandom_range(0, (1 << W) - 1));
      target = t;
      expect_clean(t);
      run_search(0, 0, 3'b000);
    end

    // reset in cycle 3 of a search
    target = 4'd9;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_guess", bus.guess, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_done", bus.done, 0);
    check("mid_rst_result", bus.result, 0);
    check("mid_rst_found", bus.found, 0);
    check("mid_rst_err", bus.err, 0);
    check("mid_rst_state", dbg_state, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_state", dbg_state, 0);
    check("post_rst_busy", bus.busy, 0);
    check("post_rst_guess", bus.guess, 0);

    // normal operation after reset
    target = 4'd5;  expect_clean(4'd5);  run_search(0, 0, 3'b000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
